axi_apb_req_scheduler: RTL and testbench

//  Front-end scheduler for the AXI-lite -> APB bridge. Captures AXI-lite write (AW/W) and read (AR)

---
 rtl/axi_apb_pkg.sv | 26 ++
 rtl/axi_lite_hold_reg.sv | 50 +++++
 rtl/axi_apb_req_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_axi_apb_req_scheduler.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_apb_pkg.sv
// Shared types and response codes for the AXI-lite to APB request scheduler.
package axi_apb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RSP,
    LOCAL_ERR,
    RESP_B,
    RESP_R
  } sched_state_t;

  typedef enum logic {
    GRANT_RD = 1'b0,
    GRANT_WR = 1'b1
  } grant_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic [1:0] engine_resp(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

endpackage

// File: rtl/axi_lite_hold_reg.sv
// One-entry valid/ready capture register; emptied only by an explicit release pulse.
module axi_lite_hold_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             release_en,
  output logic             full,
  output logic [WIDTH-1:0] out_data
);

  logic             en_q, en_d;
  logic             full_q, full_d;
  logic [WIDTH-1:0] data_q, data_d;

  // Ready stays low through reset and rises on the first edge after release.
  assign in_ready = en_q && !full_q;
  assign full     = full_q;
  assign out_data = data_q;

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    en_d   = 1'b1;
    full_d = full_q;
    data_d = data_q;
    if (release_en) full_d = 1'b0;
    if (in_valid && in_ready) begin
      full_d = 1'b1;
      data_d = in_data;
    end
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q   <= 1'b0;
      full_q <= 1'b0;
      // NOTE: the payload is reset too; it is a single register, so the cost is trivial and outputs stay deterministic.
      data_q <= '0;
    end else begin
      en_q   <= en_d;
      full_q <= full_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/axi_apb_req_scheduler.sv
// AXI-lite front end for the APB bridge: captures AW/W/AR, arbitrates round-robin,
// issues one command at a time to the APB engine and returns the result on B or R.
module axi_apb_req_scheduler
  import axi_apb_pkg::*;
#(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] WIN_BASE = '0,
  parameter logic [ADDR_W-1:0] WIN_MASK = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [DATA_W-1:0]   WDATA,
  input  logic [DATA_W/8-1:0] WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic [1:0]          BRESP,
  output logic                BVALID,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic [DATA_W-1:0]   RDATA,
  output logic [1:0]          RRESP,
  output logic                RVALID,
  input  logic                RREADY,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic                cmd_write,
  output logic [ADDR_W-1:0]   cmd_addr,
  output logic [DATA_W-1:0]   cmd_wdata,
  output logic [DATA_W/8-1:0] cmd_strb,
  input  logic                rsp_valid,
  input  logic [DATA_W-1:0]   rsp_rdata,
  input  logic                rsp_err
);

  localparam int STRB_W = DATA_W / 8;

  logic                aw_full, w_full, ar_full;
  logic [ADDR_W-1:0]   aw_addr, ar_addr;
  logic [DATA_W-1:0]   w_data;
  logic [STRB_W-1:0]   w_strb;
  logic                rel_wr, rel_rd;

  sched_state_t        state_q, state_d;
  grant_t              last_grant_q, last_grant_d;
  logic                cmd_valid_q, cmd_valid_d;
  logic                cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;
  logic [STRB_W-1:0]   cmd_strb_q, cmd_strb_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                rvalid_q, rvalid_d;
  logic [1:0]          rresp_q, rresp_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  axi_lite_hold_reg #(.WIDTH(ADDR_W)) u_aw (
    .clk(clk), .rst(rst), .in_valid(AWVALID), .in_ready(AWREADY), .in_data(AWADDR),
    .release_en(rel_wr), .full(aw_full), .out_data(aw_addr)
  );

  axi_lite_hold_reg #(.WIDTH(DATA_W + STRB_W)) u_w (
    .clk(clk), .rst(rst), .in_valid(WVALID), .in_ready(WREADY), .in_data({WDATA, WSTRB}),
    .release_en(rel_wr), .full(w_full), .out_data({w_data, w_strb})
  );

  axi_lite_hold_reg #(.WIDTH(ADDR_W)) u_ar (
    .clk(clk), .rst(rst), .in_valid(ARVALID), .in_ready(ARREADY), .in_data(ARADDR),
    .release_en(rel_rd), .full(ar_full), .out_data(ar_addr)
  );

  logic              wr_elig, rd_elig, pick_wr, in_win;
  logic [ADDR_W-1:0] grant_addr;

  assign wr_elig    = aw_full && w_full;
  assign rd_elig    = ar_full;
  assign pick_wr    = wr_elig && (!rd_elig || (last_grant_q == GRANT_RD));
  assign grant_addr = pick_wr ? aw_addr : ar_addr;
  assign in_win     = ((grant_addr & WIN_MASK) == (WIN_BASE & WIN_MASK));

  // Hold regs are freed once the command is handed off or the decode miss is answered locally.
  assign rel_wr = (last_grant_q == GRANT_WR) &&
                  (((state_q == ISSUE) && cmd_ready) || (state_q == LOCAL_ERR));
  assign rel_rd = (last_grant_q == GRANT_RD) &&
                  (((state_q == ISSUE) && cmd_ready) || (state_q == LOCAL_ERR));

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_write_d  = cmd_write_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    cmd_strb_d   = cmd_strb_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    rvalid_d     = rvalid_q;
    rresp_d      = rresp_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (wr_elig || rd_elig) begin
          last_grant_d = pick_wr ? GRANT_WR : GRANT_RD;
          if (in_win) begin
            state_d     = ISSUE;
            cmd_valid_d = 1'b1;
            cmd_write_d = pick_wr;
            cmd_addr_d  = grant_addr;
            cmd_wdata_d = pick_wr ? w_data : '0;
            cmd_strb_d  = pick_wr ? w_strb : '0;
          end else begin
            state_d = LOCAL_ERR;
          end
        end
      end
      ISSUE: begin
        if (cmd_ready) begin
          state_d     = WAIT_RSP;
          cmd_valid_d = 1'b0;
          cmd_write_d = 1'b0;
          cmd_addr_d  = '0;
          cmd_wdata_d = '0;
          cmd_strb_d  = '0;
        end
      end
      WAIT_RSP: begin
        if (rsp_valid) begin
          if (last_grant_q == GRANT_WR) begin
            state_d  = RESP_B;
            bvalid_d = 1'b1;
            bresp_d  = engine_resp(rsp_err);
          end else begin
            state_d  = RESP_R;
            rvalid_d = 1'b1;
            rresp_d  = engine_resp(rsp_err);
            rdata_d  = rsp_rdata;
          end
        end
      end
      LOCAL_ERR: begin
        if (last_grant_q == GRANT_WR) begin
          state_d  = RESP_B;
          bvalid_d = 1'b1;
          bresp_d  = RESP_DECERR;
        end else begin
          state_d  = RESP_R;
          rvalid_d = 1'b1;
          rresp_d  = RESP_DECERR;
          rdata_d  = '0;
        end
      end
      RESP_B: begin
        if (BREADY) begin
          state_d  = IDLE;
          bvalid_d = 1'b0;
        end
      end
      RESP_R: begin
        if (RREADY) begin
          state_d  = IDLE;
          rvalid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_RD;
      cmd_valid_q  <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      cmd_strb_q   <= '0;
      bvalid_q     <= 1'b0;
      bresp_q      <= '0;
      rvalid_q     <= 1'b0;
      rresp_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_write_q  <= cmd_write_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      cmd_strb_q   <= cmd_strb_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      rvalid_q     <= rvalid_d;
      rresp_q      <= rresp_d;
      rdata_q      <= rdata_d;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_write = cmd_write_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_wdata = cmd_wdata_q;
  assign cmd_strb  = cmd_strb_q;
  assign BVALID    = bvalid_q;
  assign BRESP     = bresp_q;
  assign RVALID    = rvalid_q;
  assign RRESP     = rresp_q;
  assign RDATA     = rdata_q;

  // A completion pulse with nothing outstanding is dropped by the FSM and flagged here.
  a_rsp_only_in_wait: assert property (@(posedge clk) disable iff (!rst)
    rsp_valid |-> (state_q == WAIT_RSP));

endmodule

// File: tb/tb_axi_apb_req_scheduler.sv
// Scoreboard bench: instance 0 decodes every address, instance 1 has window 0x4000_xxxx.
module tb_axi_apb_req_scheduler;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } cmd_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  resp;
    logic [31:0] data;
  } rsp_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } eng_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] awaddr [2];
  logic        awvalid [2];
  logic        awready [2];
  logic [31:0] wdata [2];
  logic [3:0]  wstrb [2];
  logic        wvalid [2];
  logic        wready [2];
  logic [1:0]  bresp [2];
  logic        bvalid [2];
  logic        bready [2];
  logic [31:0] araddr [2];
  logic        arvalid [2];
  logic        arready [2];
  logic [31:0] rdata [2];
  logic [1:0]  rresp [2];
  logic        rvalid [2];
  logic        rready [2];
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic        cmd_write [2];
  logic [31:0] cmd_addr [2];
  logic [31:0] cmd_wdata [2];
  logic [3:0]  cmd_strb [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err [2];

  cmd_t exp_cmd [2][$];
  rsp_t exp_rsp [2][$];
  eng_t eng_cfg [2][$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam logic [31:0] BASE = (g == 0) ? 32'h0 : 32'h4000_0000;
    localparam logic [31:0] MASK = (g == 0) ? 32'h0 : 32'hFFFF_0000;

    axi_apb_req_scheduler #(
      .ADDR_W(32), .DATA_W(32), .WIN_BASE(BASE), .WIN_MASK(MASK)
    ) u_dut (
      .clk(clk), .rst(rst_n),
      .AWADDR(awaddr[g]), .AWVALID(awvalid[g]), .AWREADY(awready[g]),
      .WDATA(wdata[g]), .WSTRB(wstrb[g]), .WVALID(wvalid[g]), .WREADY(wready[g]),
      .BRESP(bresp[g]), .BVALID(bvalid[g]), .BREADY(bready[g]),
      .ARADDR(araddr[g]), .ARVALID(arvalid[g]), .ARREADY(arready[g]),
      .RDATA(rdata[g]), .RRESP(rresp[g]), .RVALID(rvalid[g]), .RREADY(rready[g]),
      .cmd_valid(cmd_valid[g]), .cmd_ready(cmd_ready[g]), .cmd_write(cmd_write[g]),
      .cmd_addr(cmd_addr[g]), .cmd_wdata(cmd_wdata[g]), .cmd_strb(cmd_strb[g]),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]), .rsp_err(rsp_err[g])
    );

    // APB engine model: completion pulse two cycles after the command handshake.
    initial begin
      eng_t cfg;
      forever begin
        @(negedge clk);
        #1;
        if (rst_n && cmd_valid[g] && cmd_ready[g]) begin
          cfg = '0;
          if (eng_cfg[g].size() != 0) cfg = eng_cfg[g].pop_front();
          repeat (2) @(negedge clk);
          if (rst_n) begin
            rsp_valid[g] = 1'b1;
            rsp_rdata[g] = cfg.rdata;
            rsp_err[g]   = cfg.err;
            @(negedge clk);
            rsp_valid[g] = 1'b0;
            rsp_rdata[g] = '0;
            rsp_err[g]   = 1'b0;
          end
        end
      end
    end

    // Monitor: pops expected commands/responses and checks stability while stalled.
    initial begin
      cmd_t c, pc;
      rsp_t r;
      logic hold_c, hold_b, hold_r;
      logic [1:0] pb, pr;
      logic [31:0] pd;
      hold_c = 1'b0; hold_b = 1'b0; hold_r = 1'b0;
      pc = '0; pb = '0; pr = '0; pd = '0;
      forever begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
          hold_c = 1'b0; hold_b = 1'b0; hold_r = 1'b0;
          continue;
        end
        if (hold_c) begin
          check("cmd_valid_stable", cmd_valid[g], 1'b1);
          check("cmd_addr_stable", cmd_addr[g], pc.addr);
          check("cmd_wdata_stable", cmd_wdata[g], pc.wdata);
        end
        if (hold_b) begin
          check("bvalid_stable", bvalid[g], 1'b1);
          check("bresp_stable", bresp[g], pb);
        end
        if (hold_r) begin
          check("rvalid_stable", rvalid[g], 1'b1);
          check("rresp_stable", rresp[g], pr);
          check("rdata_stable", rdata[g], pd);
        end
        if (bvalid[g] || rvalid[g]) check("no_cmd_while_resp", cmd_valid[g], 1'b0);
        if (cmd_valid[g] && cmd_ready[g]) begin
          check("cmd_expected", exp_cmd[g].size() != 0, 1'b1);
          if (exp_cmd[g].size() != 0) begin
            c = exp_cmd[g].pop_front();
            check("cmd_write", cmd_write[g], c.wr);
            check("cmd_addr", cmd_addr[g], c.addr);
            check("cmd_wdata", cmd_wdata[g], c.wdata);
            check("cmd_strb", cmd_strb[g], c.strb);
          end
        end
        if ((bvalid[g] && bready[g]) || (rvalid[g] && rready[g])) begin
          check("rsp_expected", exp_rsp[g].size() != 0, 1'b1);
          if (exp_rsp[g].size() != 0) begin
            r = exp_rsp[g].pop_front();
            check("rsp_is_write", bvalid[g], r.wr);
            if (r.wr) begin
              check("bresp", bresp[g], r.resp);
            end else begin
              check("rresp", rresp[g], r.resp);
              check("rdata", rdata[g], r.data);
            end
          end
        end
        hold_c = cmd_valid[g] && !cmd_ready[g];
        pc     = '{cmd_write[g], cmd_addr[g], cmd_wdata[g], cmd_strb[g]};
        hold_b = bvalid[g] && !bready[g];
        pb     = bresp[g];
        hold_r = rvalid[g] && !rready[g];
        pr     = rresp[g];
        pd     = rdata[g];
      end
    end
  end

  task automatic expect_txn(input int k, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [3:0] st,
                            input logic [31:0] rd, input logic err);
    exp_cmd[k].push_back('{wr, addr, wr ? wd : 32'h0, wr ? st : 4'h0});
    eng_cfg[k].push_back('{rd, err});
    exp_rsp[k].push_back('{wr, err ? 2'b10 : 2'b00, wr ? 32'h0 : rd});
  endtask

  task automatic expect_decerr(input int k, input logic wr);
    exp_rsp[k].push_back('{wr, 2'b11, 32'h0});
  endtask

  task automatic send_aw(input int k, input logic [31:0] a);
    logic hs;
    hs = 1'b0;
    awaddr[k] = a;
    awvalid[k] = 1'b1;
    for (int i = 0; i < 200 && !hs; i++) begin
      hs = awready[k];
      @(negedge clk);
    end
    awvalid[k] = 1'b0;
    check("aw_handshake", hs, 1'b1);
  endtask

  task automatic send_w(input int k, input logic [31:0] d, input logic [3:0] s);
    logic hs;
    hs = 1'b0;
    wdata[k] = d;
    wstrb[k] = s;
    wvalid[k] = 1'b1;
    for (int i = 0; i < 200 && !hs; i++) begin
      hs = wready[k];
      @(negedge clk);
    end
    wvalid[k] = 1'b0;
    check("w_handshake", hs, 1'b1);
  endtask

  task automatic send_ar(input int k, input logic [31:0] a);
    logic hs;
    hs = 1'b0;
    araddr[k] = a;
    arvalid[k] = 1'b1;
    for (int i = 0; i < 200 && !hs; i++) begin
      hs = arready[k];
      @(negedge clk);
    end
    arvalid[k] = 1'b0;
    check("ar_handshake", hs, 1'b1);
  endtask

  task automatic wait_done(input int k);
    for (int i = 0; i < 500 && exp_rsp[k].size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("all_responses_seen", exp_rsp[k].size(), 0);
    check("all_commands_seen", exp_cmd[k].size(), 0);
  endtask

  task automatic check_ready(input int k, input logic v);
    check("awready", awready[k], v);
    check("wready", wready[k], v);
    check("arready", arready[k], v);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    for (int k = 0; k < 2; k++) begin
      awaddr[k] = '0; awvalid[k] = 1'b0; wdata[k] = '0; wstrb[k] = '0; wvalid[k] = 1'b0;
      araddr[k] = '0; arvalid[k] = 1'b0; bready[k] = 1'b1; rready[k] = 1'b1;
      cmd_ready[k] = 1'b1; rsp_valid[k] = 1'b0; rsp_rdata[k] = '0; rsp_err[k] = 1'b0;
    end

    // Reset values, then readiness only after the first edge following release.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check_ready(k, 1'b0);
      check("rst_cmd_valid", cmd_valid[k], 1'b0);
      check("rst_bvalid", bvalid[k], 1'b0);
      check("rst_rvalid", rvalid[k], 1'b0);
    end
    rst_n = 1'b1;
    #1;
    check_ready(0, 1'b0);
    @(negedge clk);
    check_ready(0, 1'b1);
    check_ready(1, 1'b1);

    // Test 1: AW and W together, B held until BREADY.
    bready[0] = 1'b0;
    expect_txn(0, 1'b1, 32'hA5A5_A5A5, 32'h1010_1010, 4'hF, 32'h0, 1'b0);
    fork
      send_aw(0, 32'hA5A5_A5A5);
      send_w(0, 32'h1010_1010, 4'hF);
    join
    for (int i = 0; i < 50 && !bvalid[0]; i++) @(negedge clk);
    check("t1_bvalid_seen", bvalid[0], 1'b1);
    repeat (3) @(negedge clk);
    check("t1_bvalid_held", bvalid[0], 1'b1);
    check("t1_bresp", bresp[0], 2'b00);
    bready[0] = 1'b1;
    wait_done(0);

    // Test 2: W three cycles ahead of AW; command exactly one cycle after AW capture.
    expect_txn(0, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 32'h0, 1'b0);
    send_w(0, 32'hDEAD_BEEF, 4'b0011);
    check("t2_wready_dropped", wready[0], 1'b0);
    check("t2_no_cmd_w_only", cmd_valid[0], 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("t2_wready_dropped", wready[0], 1'b0);
      check("t2_no_cmd_w_only", cmd_valid[0], 1'b0);
    end
    send_aw(0, 32'h0000_1000);
    check("t2_cmd_not_yet", cmd_valid[0], 1'b0);
    @(negedge clk);
    check("t2_cmd_next_cycle", cmd_valid[0], 1'b1);
    wait_done(0);

    // Test 4: read with RREADY stalled, a second (erroring) read staged meanwhile.
    rready[0] = 1'b0;
    expect_txn(0, 1'b0, 32'hA5A5_A5A5, 32'h0, 4'h0, 32'hA5A5_B7D9, 1'b0);
    send_ar(0, 32'hA5A5_A5A5);
    for (int i = 0; i < 50 && !rvalid[0]; i++) @(negedge clk);
    check("t4_rvalid_seen", rvalid[0], 1'b1);
    expect_txn(0, 1'b0, 32'h0000_0044, 32'h0, 4'h0, 32'h0, 1'b1);
    send_ar(0, 32'h0000_0044);
    repeat (4) begin
      @(negedge clk);
      check("t4_rvalid_held", rvalid[0], 1'b1);
      check("t4_rdata_held", rdata[0], 32'hA5A5_B7D9);
      check("t4_rresp_okay", rresp[0], 2'b00);
    end
    rready[0] = 1'b1;
    wait_done(0);

    // Test 3: contested grants; last grant was a read, so write, read, then write.
    expect_txn(0, 1'b1, 32'h0000_2000, 32'h1111_1111, 4'hF, 32'h0, 1'b0);
    expect_txn(0, 1'b0, 32'h0000_3000, 32'h0, 4'h0, 32'h3333_3333, 1'b0);
    expect_txn(0, 1'b1, 32'h0000_4000, 32'h4444_4444, 4'b1000, 32'h0, 1'b0);
    fork
      send_aw(0, 32'h0000_2000);
      send_w(0, 32'h1111_1111, 4'hF);
      send_ar(0, 32'h0000_3000);
    join
    fork
      send_aw(0, 32'h0000_4000);
      send_w(0, 32'h4444_4444, 4'b1000);
    join
    wait_done(0);

    // Test 5: decode window on instance 1.
    expect_decerr(1, 1'b0);
    send_ar(1, 32'h5000_0000);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | cmd_valid[1];
    end
    check("t5_no_cmd_for_miss", seen, 1'b0);
    wait_done(1);

    cmd_ready[1] = 1'b0;
    expect_txn(1, 1'b1, 32'h4000_0010, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0);
    fork
      send_aw(1, 32'h4000_0010);
      send_w(1, 32'hCAFE_F00D, 4'hF);
    join
    for (int i = 0; i < 50 && !cmd_valid[1]; i++) @(negedge clk);
    check("t5_cmd_issued", cmd_valid[1], 1'b1);
    repeat (3) @(negedge clk);
    cmd_ready[1] = 1'b1;
    wait_done(1);

    expect_decerr(1, 1'b1);
    fork
      send_aw(1, 32'h5000_0004);
      send_w(1, 32'h0123_4567, 4'hF);
    join
    wait_done(1);

    expect_txn(1, 1'b0, 32'h4000_FFFC, 32'h0, 4'h0, 32'h0BAD_F00D, 1'b0);
    send_ar(1, 32'h4000_FFFC);
    wait_done(1);

    // Test 6: reset during WAIT_RSP drops the transfer; the same write then completes.
    expect_txn(0, 1'b1, 32'hA5A5_A5A5, 32'h1010_1010, 4'hF, 32'h0, 1'b0);
    fork
      send_aw(0, 32'hA5A5_A5A5);
      send_w(0, 32'h1010_1010, 4'hF);
    join
    for (int i = 0; i < 50 && exp_cmd[0].size() != 0; i++) @(negedge clk);
    check("t6_cmd_taken", exp_cmd[0].size(), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check_ready(0, 1'b0);
    check("t6_cmd_valid", cmd_valid[0], 1'b0);
    check("t6_bvalid", bvalid[0], 1'b0);
    check("t6_rvalid", rvalid[0], 1'b0);
    check("t6_bresp", bresp[0], 2'b00);
    exp_rsp[0].delete();
    eng_cfg[0].delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_ready(0, 1'b0);
    @(negedge clk);
    check_ready(0, 1'b1);
    expect_txn(0, 1'b1, 32'hA5A5_A5A5, 32'h1010_1010, 4'hF, 32'h0, 1'b0);
    fork
      send_aw(0, 32'hA5A5_A5A5);
      send_w(0, 32'h1010_1010, 4'hF);
    join
    wait_done(0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
